multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM (fetch / decode / memory / execute / writeback).
// Optional performance counters are built when MULTICYCLE_CTRL_PERF_EN is defined:
// cycle_cnt counts cycles out of reset (frozen in ILLEGAL), instret_cnt counts
// retired instructions.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       mem_to_reg,
  output logic [3:0] state,
  output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_ILLEGAL   = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic       illegal_reg;

  assign state   = state_reg;
  assign illegal = illegal_reg;

  // State register and sticky illegal flag; active-low reset returns to FETCH
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_reg | (state_next == S_ILLEGAL);
    end
  end

  // Next-state logic; memory states wait on mem_ready, unused codes recover to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          default:            state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_next = S_ALU_WB;
      S_EXEC_I:    state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_ILLEGAL:   state_next = S_ILLEGAL;
      default:     state_next = S_FETCH;
    endcase
  end

  // Output decode per state; while reset is low strobes are forced off and selects show FETCH values
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_we = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_we     = zero;
      end
      default: ;
    endcase
    if (!reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      i_or_d     = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b01;
      alu_op     = 2'b00;
      mem_to_reg = 1'b0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] instret_cnt_reg;

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;

  // Cycle and retired-instruction counters; an instruction retires on its last state's exit to FETCH
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt_reg   <= 32'd0;
      instret_cnt_reg <= 32'd0;
    end else begin
      if (state_reg != S_ILLEGAL)
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if ((state_next == S_FETCH) &&
          ((state_reg == S_MEM_WB) || (state_reg == S_MEM_WRITE) ||
           (state_reg == S_ALU_WB) || (state_reg == S_BRANCH)))
        instret_cnt_reg <= instret_cnt_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-cycle stimulus tables, expected outputs
// queued at drive time and popped/compared once the DUT outputs settle.
// Define MULTICYCLE_CTRL_PERF_EN to also exercise the performance counters.
module tb_multicycle_control;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       reg_we;
    logic       mem_to_reg;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic       mr;
    logic       z;
    logic [3:0] st;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src, reg_we, mem_to_reg, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  obs_t sb [$];
  obs_t got, exp_v;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // Expected outputs for a given state and input combination, from the state output table
  function automatic obs_t spec_out(input logic [3:0] st, input logic rst,
                                    input logic mr, input logic z);
    obs_t o;
    o = '0;
    o.st = st;
    o.illegal = (st == 4'd15);
    case (st)
      4'd0: begin o.mem_req = 1; o.b = 2'b01; o.ir_we = mr; o.pc_we = mr; end
      4'd1: begin o.a = 2'b10; o.b = 2'b10; end
      4'd2: begin o.a = 2'b01; o.b = 2'b10; end
      4'd3: begin o.mem_req = 1; o.i_or_d = 1; end
      4'd4: begin o.reg_we = 1; o.mem_to_reg = 1; end
      4'd5: begin o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1; end
      4'd6: begin o.a = 2'b01; o.op = 2'b10; end
      4'd7: begin o.a = 2'b01; o.b = 2'b10; o.op = 2'b10; end
      4'd8: begin o.reg_we = 1; end
      4'd9: begin o.a = 2'b01; o.op = 2'b01; o.pc_src = 1; o.pc_we = z; end
      default: ;
    endcase
    if (!rst) begin
      o.mem_req = 0; o.mem_we = 0; o.ir_we = 0; o.pc_we = 0; o.reg_we = 0;
      o.i_or_d = 0; o.pc_src = 0; o.a = 2'b00; o.b = 2'b01; o.op = 2'b00; o.mem_to_reg = 0;
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{st: state, mem_req: mem_req, mem_we: mem_we, i_or_d: i_or_d, ir_we: ir_we,
          pc_we: pc_we, pc_src: pc_src, a: alu_src_a, b: alu_src_b, op: alu_op,
          reg_we: reg_we, mem_to_reg: mem_to_reg, illegal: illegal};
    return o;
  endfunction

  // Drive one cycle of inputs after the falling edge and queue the expected outputs
  task automatic apply(input stim_t s);
    @(negedge clk);
    reset     = s.rst;
    opcode    = s.op;
    mem_ready = s.mr;
    zero      = s.z;
    sb.push_back(spec_out(s.st, s.rst, s.mr, s.z));
    #1;
  endtask

  task automatic test_reset();
    stim_t tbl [2];
    tbl = '{'{1'b0, OP_R, 1'b1, 1'b1, 4'd0}, '{1'b0, OP_R, 1'b1, 1'b1, 4'd0}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = sample(); exp_v = sb.pop_front(); checks++;
      $display("tx reset #%0d state=%0d outs=%h", i, got.st, got);
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_rtype();
    stim_t tbl [4];
    tbl = '{'{1'b1, OP_R, 1'b1, 1'b0, 4'd0}, '{1'b1, OP_R, 1'b0, 1'b0, 4'd1},
            '{1'b1, OP_R, 1'b1, 1'b1, 4'd6}, '{1'b1, OP_R, 1'b0, 1'b0, 4'd8}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = sample(); exp_v = sb.pop_front(); checks++;
      $display("tx rtype #%0d state=%0d outs=%h", i, got.st, got);
      if (got !== exp_v) begin
        errors++;
        $display("FAIL rtype[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_load_wait();
    stim_t tbl [9];
    tbl = '{'{1'b1, OP_LOAD, 1'b0, 1'b0, 4'd0}, '{1'b1, OP_LOAD, 1'b1, 1'b0, 4'd0},
            '{1'b1, OP_LOAD, 1'b1, 1'b0, 4'd1}, '{1'b1, OP_LOAD, 1'b1, 1'b0, 4'd2},
            '{1'b1, OP_LOAD, 1'b0, 1'b0, 4'd3}, '{1'b1, OP_LOAD, 1'b0, 1'b0, 4'd3},
            '{1'b1, OP_LOAD, 1'b0, 1'b0, 4'd3}, '{1'b1, OP_LOAD, 1'b1, 1'b0, 4'd3},
            '{1'b1, OP_LOAD, 1'b0, 1'b0, 4'd4}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = sample(); exp_v = sb.pop_front(); checks++;
      $display("tx load #%0d state=%0d outs=%h", i, got.st, got);
      if (got !== exp_v) begin
        errors++;
        $display("FAIL load[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_store_itype();
    stim_t tbl [8];
    tbl = '{'{1'b1, OP_STORE, 1'b1, 1'b0, 4'd0}, '{1'b1, OP_STORE, 1'b1, 1'b0, 4'd1},
            '{1'b1, OP_STORE, 1'b1, 1'b0, 4'd2}, '{1'b1, OP_STORE, 1'b1, 1'b0, 4'd5},
            '{1'b1, OP_I,     1'b1, 1'b0, 4'd0}, '{1'b1, OP_I,     1'b1, 1'b0, 4'd1},
            '{1'b1, OP_I,     1'b1, 1'b0, 4'd7}, '{1'b1, OP_I,     1'b1, 1'b0, 4'd8}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = sample(); exp_v = sb.pop_front(); checks++;
      $display("tx store_i #%0d state=%0d outs=%h", i, got.st, got);
      if (got !== exp_v) begin
        errors++;
        $display("FAIL store_i[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_branch();
    stim_t tbl [6];
    tbl = '{'{1'b1, OP_BRANCH, 1'b1, 1'b1, 4'd0}, '{1'b1, OP_BRANCH, 1'b1, 1'b1, 4'd1},
            '{1'b1, OP_BRANCH, 1'b1, 1'b1, 4'd9}, '{1'b1, OP_BRANCH, 1'b1, 1'b0, 4'd0},
            '{1'b1, OP_BRANCH, 1'b1, 1'b0, 4'd1}, '{1'b1, OP_BRANCH, 1'b1, 1'b0, 4'd9}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = sample(); exp_v = sb.pop_front(); checks++;
      $display("tx branch #%0d state=%0d pc_we=%0b pc_src=%0b", i, got.st, got.pc_we, got.pc_src);
      if (got !== exp_v) begin
        errors++;
        $display("FAIL branch[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    stim_t tbl [8];
    tbl = '{'{1'b1, OP_STORE, 1'b1, 1'b0, 4'd0}, '{1'b1, OP_STORE, 1'b1, 1'b0, 4'd1},
            '{1'b1, OP_STORE, 1'b1, 1'b0, 4'd2}, '{1'b1, OP_STORE, 1'b0, 1'b0, 4'd5},
            '{1'b1, OP_STORE, 1'b0, 1'b0, 4'd5}, '{1'b0, OP_STORE, 1'b0, 1'b0, 4'd5},
            '{1'b0, OP_STORE, 1'b1, 1'b0, 4'd0}, '{1'b1, OP_STORE, 1'b0, 1'b0, 4'd0}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      got = sample(); exp_v = sb.pop_front(); checks++;
      $display("tx rst_store #%0d state=%0d mem_req=%0b mem_we=%0b", i, got.st, got.mem_req, got.mem_we);
      if (got !== exp_v) begin
        errors++;
        $display("FAIL rst_store[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_illegal();
    stim_t s;
    for (int i = 0; i < 15; i++) begin
      if (i == 0)       s = '{1'b1, OP_BAD, 1'b1, 1'b0, 4'd0};
      else if (i == 1)  s = '{1'b1, OP_BAD, 1'b0, 1'b0, 4'd1};
      else if (i < 12)  s = '{1'b1, OP_BAD, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'd15};
      else if (i == 12) s = '{1'b0, OP_BAD, 1'b1, 1'b1, 4'd15};
      else if (i == 13) s = '{1'b0, OP_BAD, 1'b1, 1'b0, 4'd0};
      else              s = '{1'b1, OP_BAD, 1'b0, 1'b0, 4'd0};
      apply(s);
      got = sample(); exp_v = sb.pop_front(); checks++;
      $display("tx illegal #%0d state=%0d illegal=%0b", i, got.st, got.illegal);
      if (got !== exp_v) begin
        errors++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
  endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
  task automatic test_perf();
    stim_t s;
    logic [3:0] rseq [4];
    rseq = '{4'd0, 4'd1, 4'd6, 4'd8};
    for (int i = 0; i < 14; i++) begin
      if (i == 0)       s = '{1'b0, OP_R, 1'b1, 1'b0, 4'd0};
      else if (i < 13)  s = '{1'b1, OP_R, 1'b1, 1'b0, rseq[(i - 1) % 4]};
      else              s = '{1'b1, OP_R, 1'b0, 1'b0, 4'd0};
      apply(s);
      got = sample(); exp_v = sb.pop_front(); checks++;
      $display("tx perf #%0d state=%0d cyc=%0d inst=%0d", i, got.st, cycle_cnt, instret_cnt);
      if (got !== exp_v) begin
        errors++;
        $display("FAIL perf_state[%0d]: got %h expected %h", i, got, exp_v);
      end
    end
    checks++;
    if (cycle_cnt !== 32'd12) begin
      errors++;
      $display("FAIL cycle_cnt: got %0d expected 12", cycle_cnt);
    end
    checks++;
    if (instret_cnt !== 32'd3) begin
      errors++;
      $display("FAIL instret_cnt: got %0d expected 3", instret_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; opcode = OP_R; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk);
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_itype();
    test_branch();
    test_reset_mid_store();
`ifdef MULTICYCLE_CTRL_PERF_EN
    test_perf();
`endif
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
